// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants up to two of LSU/MDU/ALU per cycle onto register file ports B then A.
// Optional pending-write busy scoreboard is built when WB_ARB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lsu_valid_i,
  output logic                    lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_data_i,
  input  logic                    mdu_valid_i,
  output logic                    mdu_ready_o,
  input  logic [ADDR_WIDTH-1:0]   mdu_addr_i,
  input  logic [DATA_WIDTH-1:0]   mdu_data_i,
  input  logic                    alu_valid_i,
  output logic                    alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]   alu_addr_i,
  input  logic [DATA_WIDTH-1:0]   alu_data_i,
  output logic [ADDR_WIDTH-1:0]   waddr_a_o,
  output logic [DATA_WIDTH-1:0]   wdata_a_o,
  output logic                    we_a_o,
  output logic [ADDR_WIDTH-1:0]   waddr_b_o,
  output logic [DATA_WIDTH-1:0]   wdata_b_o,
  output logic                    we_b_o
`ifdef WB_ARB_SCOREBOARD_EN
  ,
  input  logic                    rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]   rsv_addr_i,
  output logic [2**ADDR_WIDTH-1:0] busy_o
`endif
);

  localparam int unsigned NREQ = 3;

  logic [NREQ-1:0]       w_valid;
  logic [NREQ-1:0]       w_grant;
  logic [NREQ-1:0]       w_promo;
  logic [ADDR_WIDTH-1:0] w_addr [NREQ];
  logic [DATA_WIDTH-1:0] w_data [NREQ];
  logic [3:0]            r_cnt  [NREQ];
  logic                  w_use_a, w_use_b;
  logic [1:0]            w_sel_a, w_sel_b;
  logic [ADDR_WIDTH-1:0] w_first;

  logic                  r_we_a, r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_a, r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_a, r_wdata_b;

  assign w_valid = {alu_valid_i, mdu_valid_i, lsu_valid_i};
  assign w_addr[0] = lsu_addr_i;
  assign w_addr[1] = mdu_addr_i;
  assign w_addr[2] = alu_addr_i;
  assign w_data[0] = lsu_data_i;
  assign w_data[1] = mdu_data_i;
  assign w_data[2] = alu_data_i;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_promo[i] = (r_cnt[i] >= 4'(STARVE_LIMIT));
    end
  end

  // Pass 0 visits promoted requesters, pass 1 the rest; base order within each pass.
  always_comb begin
    w_grant = '0;
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    w_sel_a = '0;
    w_sel_b = '0;
    w_first = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_valid[i] && !rst && (w_promo[i] == (p == 0))) begin
          if (w_addr[i] == '0) begin
            w_grant[i] = 1'b1;
          end else if (!w_use_b) begin
            w_grant[i] = 1'b1;
            w_use_b    = 1'b1;
            w_sel_b    = 2'(i);
            w_first    = w_addr[i];
          end else if (!w_use_a && (w_addr[i] != w_first)) begin
            w_grant[i] = 1'b1;
            w_use_a    = 1'b1;
            w_sel_a    = 2'(i);
          end
        end
      end
    end
  end

  assign lsu_ready_o = w_grant[0];
  assign mdu_ready_o = w_grant[1];
  assign alu_ready_o = w_grant[2];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst || !w_valid[i] || w_grant[i]) begin
        r_cnt[i] <= '0;
      end else if (r_cnt[i] != 4'hF) begin
        r_cnt[i] <= r_cnt[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_waddr_a <= '0;
      r_waddr_b <= '0;
      r_wdata_a <= '0;
      r_wdata_b <= '0;
    end else begin
      r_we_a <= w_use_a;
      r_we_b <= w_use_b;
      if (w_use_a) begin
        r_waddr_a <= w_addr[w_sel_a];
        r_wdata_a <= w_data[w_sel_a];
      end
      if (w_use_b) begin
        r_waddr_b <= w_addr[w_sel_b];
        r_wdata_b <= w_data[w_sel_b];
      end
    end
  end

  // Write enables are masked by rst so a write registered just before reset never reaches the file.
  assign we_a_o    = r_we_a & ~rst;
  assign we_b_o    = r_we_b & ~rst;
  assign waddr_a_o = r_waddr_a;
  assign waddr_b_o = r_waddr_b;
  assign wdata_a_o = r_wdata_a;
  assign wdata_b_o = r_wdata_b;

`ifdef WB_ARB_SCOREBOARD_EN
  logic [2**ADDR_WIDTH-1:0] r_busy;
  logic [2**ADDR_WIDTH-1:0] w_busy_nxt;

  // Set is applied after clear so a same-cycle reservation wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we_a_o) w_busy_nxt[waddr_a_o] = 1'b0;
    if (we_b_o) w_busy_nxt[waddr_b_o] = 1'b0;
    if (rsv_valid_i && (rsv_addr_i != '0)) w_busy_nxt[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy_o = r_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: constant vector table, hand sequences, and
// randomized traffic against a priority-list reference model.
module tb_regfile_wb_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tv;
  logic [4:0]  ta [3];
  logic [31:0] td [3];
  logic        lsu_rdy, mdu_rdy, alu_rdy;
  logic [2:0]  rdy;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b;
`ifdef WB_ARB_SCOREBOARD_EN
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [31:0] busy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rdy = {alu_rdy, mdu_rdy, lsu_rdy};

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(tv[0]), .lsu_ready_o(lsu_rdy), .lsu_addr_i(ta[0]), .lsu_data_i(td[0]),
    .mdu_valid_i(tv[1]), .mdu_ready_o(mdu_rdy), .mdu_addr_i(ta[1]), .mdu_data_i(td[1]),
    .alu_valid_i(tv[2]), .alu_ready_o(alu_rdy), .alu_addr_i(ta[2]), .alu_data_i(td[2]),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b)
`ifdef WB_ARB_SCOREBOARD_EN
    , .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .busy_o(busy)
`endif
  );

  // Reference model: per-requester denied counts, ports hold last granted write.
  int          mcnt [3];
  logic        m_we_a, m_we_b;
  logic [4:0]  m_addr_a, m_addr_b;
  logic [31:0] m_data_a, m_data_b;

  function automatic void model_arb(output logic [2:0] g, output int b_idx, output int a_idx);
    int order[$];
    int taken[$];
    g = '0;
    b_idx = -1;
    a_idx = -1;
    for (int i = 0; i < 3; i++) if (mcnt[i] >= STARVE) order.push_back(i);
    for (int i = 0; i < 3; i++) if (mcnt[i] <  STARVE) order.push_back(i);
    if (rst) return;
    foreach (order[k]) begin
      int r;
      r = order[k];
      if (tv[r]) begin
        if (ta[r] == 0) begin
          g[r] = 1'b1;
        end else if (taken.size() < 2 && !(taken.size() == 1 && taken[0] == int'(ta[r]))) begin
          g[r] = 1'b1;
          taken.push_back(int'(ta[r]));
          if (b_idx < 0) b_idx = r;
          else           a_idx = r;
        end
      end
    end
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    m_we_a = 0; m_we_b = 0; m_addr_a = 0; m_addr_b = 0; m_data_a = 0; m_data_b = 0;
  end

  always @(posedge clk) begin : mdl
    logic [2:0] g;
    int b, a;
    model_arb(g, b, a);
    if (rst) begin
      for (int i = 0; i < 3; i++) mcnt[i] <= 0;
      m_we_a <= 0; m_we_b <= 0;
      m_addr_a <= 0; m_addr_b <= 0; m_data_a <= 0; m_data_b <= 0;
    end else begin
      for (int i = 0; i < 3; i++)
        mcnt[i] <= (tv[i] && !g[i]) ? ((mcnt[i] < 15) ? mcnt[i] + 1 : 15) : 0;
      m_we_b <= (b >= 0);
      m_we_a <= (a >= 0);
      if (b >= 0) begin m_addr_b <= ta[b]; m_data_b <= td[b]; end
      if (a >= 0) begin m_addr_a <= ta[a]; m_data_a <= td[a]; end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int i, input logic [4:0] a);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(a);
  endfunction

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    tv = v;
    ta[0] = a0; ta[1] = a1; ta[2] = a2;
    for (int k = 0; k < 3; k++) td[k] = dat(k, ta[k]);
  endtask

  typedef struct {
    logic [2:0] v;
    logic [4:0] a0, a1, a2;
    logic [2:0] rdy;
    logic       web;
    logic [4:0] ab;
    int         bs;
    logic       wea;
    logic [4:0] aa;
    int         as;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [2:0] g, last_rdy;
    int b, a;

    vecs[0] = '{3'b001, 5'd5,  5'd0, 5'd0,  3'b001, 1, 5'd5,  0, 0, 5'd0, 0};
    vecs[1] = '{3'b111, 5'd3,  5'd4, 5'd7,  3'b011, 1, 5'd3,  0, 1, 5'd4, 1};
    vecs[2] = '{3'b111, 5'd9,  5'd9, 5'd2,  3'b101, 1, 5'd9,  0, 1, 5'd2, 2};
    vecs[3] = '{3'b100, 5'd0,  5'd0, 5'd0,  3'b100, 0, 5'd0,  0, 0, 5'd0, 0};
    vecs[4] = '{3'b111, 5'd0,  5'd6, 5'd6,  3'b011, 1, 5'd6,  1, 0, 5'd0, 0};
    vecs[5] = '{3'b000, 5'd1,  5'd2, 5'd3,  3'b000, 0, 5'd0,  0, 0, 5'd0, 0};
    vecs[6] = '{3'b111, 5'd0,  5'd0, 5'd0,  3'b111, 0, 5'd0,  0, 0, 5'd0, 0};
    vecs[7] = '{3'b110, 5'd0,  5'd8, 5'd9,  3'b110, 1, 5'd8,  1, 1, 5'd9, 2};
    vecs[8] = '{3'b101, 5'd12, 5'd0, 5'd12, 3'b001, 1, 5'd12, 0, 0, 5'd0, 0};

    rst = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3);
`ifdef WB_ARB_SCOREBOARD_EN
    rsv_valid = 1'b0;
    rsv_addr  = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(rdy), 0);
    chk("rst_we_a", 64'(we_a), 0);
    chk("rst_we_b", 64'(we_b), 0);
    chk("rst_addr", 64'({waddr_a, waddr_b}), 0);
    chk("rst_data", {wdata_a, wdata_b}, 0);
`ifdef WB_ARB_SCOREBOARD_EN
    chk("rst_busy", 64'(busy), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 0, 0, 0);

    // Spec example: single LSU write lands on port B.
    @(negedge clk);
    drive(3'b001, 5'd5, 0, 0);
    td[0] = 32'hA5A5_A5A5;
    #1 chk("lsu_single_ready", 64'(lsu_rdy), 1);
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    #1;
    chk("lsu_single_we_b", 64'(we_b), 1);
    chk("lsu_single_addr_b", 64'(waddr_b), 5);
    chk("lsu_single_data_b", 64'(wdata_b), 64'h A5A5_A5A5);
    chk("lsu_single_we_a", 64'(we_a), 0);

    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      drive(vecs[n].v, vecs[n].a0, vecs[n].a1, vecs[n].a2);
      #1 chk($sformatf("vec%0d_ready", n), 64'(rdy), 64'(vecs[n].rdy));
      @(negedge clk);
      drive(3'b000, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d_we_b", n), 64'(we_b), 64'(vecs[n].web));
      chk($sformatf("vec%0d_we_a", n), 64'(we_a), 64'(vecs[n].wea));
      if (vecs[n].web) begin
        chk($sformatf("vec%0d_addr_b", n), 64'(waddr_b), 64'(vecs[n].ab));
        chk($sformatf("vec%0d_data_b", n), 64'(wdata_b), 64'(dat(vecs[n].bs, vecs[n].ab)));
      end
      if (vecs[n].wea) begin
        chk($sformatf("vec%0d_addr_a", n), 64'(waddr_a), 64'(vecs[n].aa));
        chk($sformatf("vec%0d_data_a", n), 64'(wdata_a), 64'(dat(vecs[n].as, vecs[n].aa)));
      end
    end

    // Starvation: ALU denied four cycles, promoted on the fifth.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(3'b111, 5'd3, 5'd4, 5'd7);
      #1 chk($sformatf("starve_c%0d_ready", k), 64'(rdy), (k < 5) ? 64'b011 : 64'b101);
    end
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    #1;
    chk("starve_port_b", 64'({we_b, waddr_b}), 64'({1'b1, 5'd7}));
    chk("starve_port_a", 64'({we_a, waddr_a}), 64'({1'b1, 5'd3}));

    // Same-address conflict: MDU stalls one cycle then issues.
    @(negedge clk);
    drive(3'b111, 5'd9, 5'd9, 5'd2);
    #1 chk("conflict_ready", 64'(rdy), 64'b101);
    @(negedge clk);
    drive(3'b010, 5'd9, 5'd9, 5'd2);
    #1;
    chk("conflict_ports", 64'({we_b, waddr_b, we_a, waddr_a}), 64'({1'b1, 5'd9, 1'b1, 5'd2}));
    chk("conflict_mdu_ready", 64'(rdy), 64'b010);
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    #1 chk("conflict_mdu_write", 64'({we_b, waddr_b, we_a}), 64'({1'b1, 5'd9, 1'b0}));

    // Reset mid-operation: registered write suppressed, MDU reissued afterwards.
    @(negedge clk);
    drive(3'b010, 0, 5'd11, 0);
    #1 chk("rstmid_pre_ready", 64'(rdy), 64'b010);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk($sformatf("rstmid%0d_ready", k), 64'(rdy), 0);
      chk($sformatf("rstmid%0d_we", k), 64'({we_a, we_b}), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstmid_post_ready", 64'(rdy), 64'b010);
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    #1 chk("rstmid_post_write", 64'({we_b, waddr_b, wdata_b}), 64'({1'b1, 5'd11, dat(1, 5'd11)}));

`ifdef WB_ARB_SCOREBOARD_EN
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    @(negedge clk);
    rsv_valid = 1'b0;
    #1 chk("sb_set", 64'(busy[12]), 1);
    drive(3'b100, 0, 0, 5'd12);
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    #1 chk("sb_during_we", 64'({we_b, busy[12]}), 64'b11);
    @(negedge clk);
    #1 chk("sb_cleared", 64'(busy[12]), 0);
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    @(negedge clk);
    rsv_valid = 1'b0;
    drive(3'b100, 0, 0, 5'd12);
    @(negedge clk);
    drive(3'b000, 0, 0, 0);
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1 chk("sb_set_wins", 64'(busy[12]), 1);
    @(negedge clk);
    rsv_valid = 1'b0;
    #1 chk("sb_x0_never", 64'(busy[0]), 0);
`endif

    // Randomized traffic against the reference model; stalled requests hold addr/data.
    last_rdy = '1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 3; k++) begin
        if (!(tv[k] && !last_rdy[k])) begin
          tv[k] = ($urandom_range(0, 3) != 0);
          ta[k] = 5'($urandom_range(0, 5));
          td[k] = $urandom;
        end
      end
      #1;
      model_arb(g, b, a);
      chk("rnd_ready", 64'(rdy), 64'(g));
      chk("rnd_we_b", 64'(we_b), 64'(m_we_b && !rst));
      chk("rnd_we_a", 64'(we_a), 64'(m_we_a && !rst));
      chk("rnd_port_b", 64'({waddr_b, wdata_b}), 64'({m_addr_b, m_data_b}));
      chk("rnd_port_a", 64'({waddr_a, wdata_a}), 64'({m_addr_a, m_data_a}));
      last_rdy = g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
